// File: rtl/seq_multiplier_n.sv
// Sequential N x N multiplier: shift-add for unsigned operands, radix-2 Booth for signed ones.
// Define EARLY_DONE_EN to end unsigned runs once the remaining multiplier bits are all zero.
module seq_multiplier_n #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   B,
    input  logic [N-1:0]   Q,
    output logic [2*N-1:0] A,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_reg;
    logic [N:0]    hi_reg;
    logic [N-1:0]  lo_reg;
    logic          qm1_reg;
    logic [N-1:0]  mcand_reg;
    logic          mode_reg;
    logic [CW-1:0] cnt_reg;

    logic [N:0]    b_ext;
    logic [N:0]    sum;
    logic [N:0]    hi_shift;
    logic [N-1:0]  lo_shift;

    // The upper half is N+1 bits wide so -2^(N-1) * -2^(N-1) cannot overflow.
    assign b_ext = mode_reg ? {mcand_reg[N-1], mcand_reg} : {1'b0, mcand_reg};

    always_comb begin
        sum = hi_reg;
        if (!mode_reg) begin
            if (lo_reg[0])
                sum = hi_reg + b_ext;
        end else begin
            case ({lo_reg[0], qm1_reg})
                2'b01:   sum = hi_reg + b_ext;
                2'b10:   sum = hi_reg - b_ext;
                default: sum = hi_reg;
            endcase
        end
        hi_shift = {mode_reg & sum[N], sum[N:1]};
        lo_shift = {sum[0], lo_reg[N-1:1]};
    end

`ifdef EARLY_DONE_EN
    logic [N-2:0]   rem_reg;
    logic [CW-1:0]  shamt;
    logic [2*N-1:0] aligned;

    // Skipped iterations would only shift right, so apply that shift in one step.
    assign shamt   = LAST - cnt_reg;
    assign aligned = {hi_shift[N-1:0], lo_shift} >> shamt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            qm1_reg   <= 1'b0;
            mcand_reg <= '0;
            mode_reg  <= 1'b0;
            cnt_reg   <= '0;
            A         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef EARLY_DONE_EN
            rem_reg   <= '0;
`endif
        end else begin
            busy <= (state_reg == RUN);
            done <= (state_reg == DONE);
            if (state_reg == DONE)
                A <= {hi_reg[N-1:0], lo_reg};

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_reg <= B;
                        mode_reg  <= signed_mode;
                        hi_reg    <= '0;
                        lo_reg    <= Q;
                        qm1_reg   <= 1'b0;
                        cnt_reg   <= '0;
`ifdef EARLY_DONE_EN
                        rem_reg   <= Q[N-1:1];
                        state_reg <= (!signed_mode && Q == '0) ? DONE : RUN;
`else
                        state_reg <= RUN;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    hi_reg  <= hi_shift;
                    lo_reg  <= lo_shift;
                    qm1_reg <= lo_reg[0];
                    if (cnt_reg == LAST)
                        state_reg <= DONE;
`ifdef EARLY_DONE_EN
                    rem_reg <= rem_reg >> 1;
                    if (!mode_reg && rem_reg == '0) begin
                        hi_reg    <= {1'b0, aligned[2*N-1:N]};
                        lo_reg    <= aligned[N-1:0];
                        state_reg <= DONE;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
